ifu_fetch: RTL and testbench

- Instruction fetch stage: sole master of inst_bus; generates sequential PCs and queues fetched words in a small FIFO.
- Hands {pc, inst, fault} packets to decode over a valid/ready interface.
- Handles redirects from branch/trap/mret, I-cache fence_i sequencing, and fetch-side exceptions (misaligned target, access fault).

---
 rtl/ifu_fetch_pkg.sv | 22 ++
 rtl/ifu_fetch_fifo.sv | 59 +++++
 rtl/ifu_fetch.sv | 190 +++++++++++++++++++
 tb/tb_ifu_fetch.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// Fetch stage shared types: buffer entry layout, FSM states, fetch exception codes.
// Imported by the fetch FIFO and the fetch stage top.
package ifu_fetch_pkg;

  localparam logic [3:0] EXC_INSTR_MISALIGN  = 4'd0;
  localparam logic [3:0] EXC_INSTR_ACC_FAULT = 4'd1;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic [3:0]  exc_code;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    FENCE,
    HALT
  } ifu_state_e;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Fetch buffer: power-of-2 ring of fetch entries with synchronous flush.
// Head is read combinationally; flush overrides push and pop.
module ifu_fetch_fifo
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  fetch_entry_t             din_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output fetch_entry_t             head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   rptr_q;
  logic [CW-1:0]   cnt_q;
  logic            do_push;
  logic            do_pop;

  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~flush_i & (cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rptr_q];

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(do_push && cnt_q == CW'(DEPTH))
  );

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: drives inst_bus, buffers fetched words, handles
// redirects, fence_i sequencing and fetch-side exceptions.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h8000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  input  logic        fence_i_req,
  output logic [63:0] ibus_addr,
  output logic        ibus_en,
  output logic        ibus_ready,
  output logic        ibus_fence_i,
  input  logic [31:0] ibus_rdata,
  input  logic        ibus_valid,
  input  logic        ibus_acc_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_exc,
  output logic [3:0]  out_exc_code
);

  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CW1 = CW + 1;

  ifu_state_e   state_q, state_d;
  logic [63:0]  addr_q, addr_d;
  logic [63:0]  tgt_q, tgt_d;
  logic         en_q, en_d;
  logic         fpend_q, fpend_d;
  logic         mis_q, mis_d;

  logic         hs;
  logic         push;
  logic         pop;
  logic         flush;
  logic         room;
  logic         redir_mis;
  fetch_entry_t push_ent;
  fetch_entry_t head;
  logic [CW-1:0] count;

  assign hs        = en_q & ibus_valid;
  assign pop       = (count != '0) & out_ready;
  assign redir_mis = redirect_pc[1:0] != 2'b00;
  // free slot after this edge, assuming any handshake this cycle is pushed
  assign room = (CW1'(count) + CW1'(hs)) < (CW1'(FIFO_DEPTH) + CW1'(pop));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    tgt_d    = tgt_q;
    en_d     = en_q;
    fpend_d  = fpend_q;
    mis_d    = mis_q;
    push     = 1'b0;
    flush    = 1'b0;
    push_ent = '{
      pc:       addr_q,
      inst:     ibus_acc_err ? 32'h0 : ibus_rdata,
      exc:      ibus_acc_err,
      exc_code: ibus_acc_err ? EXC_INSTR_ACC_FAULT : 4'h0
    };
    if (redirect_en) begin
      flush   = 1'b1;
      tgt_d   = redirect_pc;
      fpend_d = fence_i_req;
      mis_d   = redir_mis;
      if (en_q && !hs) begin
        state_d = DRAIN;
      end else begin
        addr_d = redirect_pc;
        en_d   = 1'b0;
        if (fence_i_req) begin
          state_d = FENCE;
        end else if (redir_mis) begin
          state_d = HALT;
        end else begin
          state_d = RUN;
          en_d    = 1'b1;
        end
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (hs) begin
            push = 1'b1;
            if (ibus_acc_err) begin
              en_d    = 1'b0;
              state_d = HALT;
            end else begin
              addr_d = addr_q + 64'd4;
              en_d   = room;
            end
          end else if (!en_q) begin
            en_d = room;
          end
        end
        DRAIN: begin
          if (hs) begin
            addr_d = tgt_q;
            en_d   = 1'b0;
            if (fpend_q) begin
              state_d = FENCE;
            end else if (mis_q) begin
              state_d = HALT;
            end else begin
              state_d = RUN;
              en_d    = 1'b1;
            end
          end
        end
        FENCE: begin
          fpend_d = 1'b0;
          addr_d  = tgt_q;
          en_d    = 1'b0;
          if (mis_q) begin
            state_d = HALT;
          end else begin
            state_d = RUN;
            en_d    = 1'b1;
          end
        end
        HALT: begin
          en_d = 1'b0;
          if (mis_q) begin
            push     = 1'b1;
            mis_d    = 1'b0;
            push_ent = '{
              pc:       tgt_q,
              inst:     32'h0,
              exc:      1'b1,
              exc_code: EXC_INSTR_MISALIGN
            };
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      addr_q  <= RESET_PC;
      tgt_q   <= RESET_PC;
      en_q    <= 1'b0;
      fpend_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tgt_q   <= tgt_d;
      en_q    <= en_d;
      fpend_q <= fpend_d;
      mis_q   <= mis_d;
    end
  end

  ifu_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (push_ent),
    .pop_i   (pop),
    .flush_i (flush),
    .count_o (count),
    .head_o  (head)
  );

  assign ibus_addr    = addr_q;
  assign ibus_en      = en_q;
  assign ibus_ready   = en_q;
  assign ibus_fence_i = state_q == FENCE;

  assign out_valid    = count != '0;
  assign out_pc       = head.pc;
  assign out_inst     = head.inst;
  assign out_exc      = head.exc;
  assign out_exc_code = head.exc_code;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios plus random traffic checked
// against a transaction-level model of the fetch stream.
module tb_ifu_fetch;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_en = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        fence_i_req = 1'b0;
  logic [63:0] ibus_addr;
  logic        ibus_en;
  logic        ibus_ready;
  logic        ibus_fence_i;
  logic [31:0] ibus_rdata = '0;
  logic        ibus_valid = 1'b0;
  logic        ibus_acc_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_exc;
  logic [3:0]  out_exc_code;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .fence_i_req  (fence_i_req),
    .ibus_addr    (ibus_addr),
    .ibus_en      (ibus_en),
    .ibus_ready   (ibus_ready),
    .ibus_fence_i (ibus_fence_i),
    .ibus_rdata   (ibus_rdata),
    .ibus_valid   (ibus_valid),
    .ibus_acc_err (ibus_acc_err),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .out_exc      (out_exc),
    .out_exc_code (out_exc_code)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [63:0] a);
    return a[31:0] ^ 32'h5A3C_96E1;
  endfunction

  // model state: expected packets, next expected fetch PC, bus expectations
  logic [63:0] q_pc[$];
  logic [36:0] q_body[$];
  logic [63:0] exp_pc = RST_PC;
  bit          halted = 0;
  bit          drain = 0;
  bit          fence_exp = 0;
  bit          have_prev = 0;
  bit          p_en = 0;
  bit          p_hs = 0;
  logic [63:0] p_addr = '0;
  int          hs_cnt = 0;
  int          npop = 0;

  task automatic model_step();
    bit hs;
    bit popv;
    hs   = ibus_en && ibus_valid;
    popv = out_valid && out_ready;
    chk("ready_tie", 64'(ibus_ready), 64'(ibus_en));
    if (have_prev && p_en && !p_hs) begin
      chk("hold_en", 64'(ibus_en), 64'd1);
      chk("hold_addr", ibus_addr, p_addr);
    end
    if (halted && !drain) chk("halt_idle", 64'(ibus_en), 64'd0);
    if (out_valid && q_pc.size() == 0)
      chk("spurious_valid", 64'(out_valid), 64'd0);
    if (popv && !redirect_en && q_pc.size() != 0) begin
      chk("out_pc", out_pc, q_pc.pop_front());
      chk("out_body", 64'({out_inst, out_exc, out_exc_code}),
          64'(q_body.pop_front()));
      npop++;
    end
    if (ibus_fence_i) begin
      chk("fence_req", 64'(fence_exp), 64'd1);
      fence_exp = 0;
    end
    if (hs) hs_cnt++;
    if (redirect_en) begin
      q_pc.delete();
      q_body.delete();
      drain     = ibus_en && !hs;
      exp_pc    = redirect_pc;
      fence_exp = fence_i_req;
      halted    = 0;
      if (redirect_pc[1:0] != 2'b00) begin
        q_pc.push_back(redirect_pc);
        q_body.push_back({32'h0, 1'b1, 4'd0});
        halted = 1;
      end
    end else if (hs && drain) begin
      drain = 0;
    end else if (hs) begin
      chk("fetch_addr", ibus_addr, exp_pc);
      chk("fence_first", 64'(fence_exp), 64'd0);
      q_pc.push_back(exp_pc);
      if (ibus_acc_err) begin
        q_body.push_back({32'h0, 1'b1, 4'd1});
        halted = 1;
      end else begin
        q_body.push_back({memf(exp_pc), 1'b0, 4'd0});
        exp_pc = exp_pc + 64'd4;
      end
    end
    p_en      = ibus_en;
    p_hs      = hs;
    p_addr    = ibus_addr;
    have_prev = 1;
  endtask

  task automatic tick();
    ibus_rdata = memf(ibus_addr);
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic restart(input logic [63:0] pc, input logic fence);
    redirect_en  = 1'b1;
    redirect_pc  = pc;
    fence_i_req  = fence;
    ibus_valid   = 1'b1;
    ibus_acc_err = 1'b0;
    tick();
    redirect_en  = 1'b0;
    fence_i_req  = 1'b0;
  endtask

  initial begin
    int h0;
    int off;
    @(negedge clk);
    @(negedge clk);
    chk("rst_en", 64'(ibus_en), 64'd0);
    chk("rst_addr", ibus_addr, RST_PC);
    chk("rst_fence", 64'(ibus_fence_i), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    chk("en_after_release", 64'(ibus_en), 64'd0);

    // sequential stream, always-ready cache and decode
    ibus_valid = 1'b1;
    out_ready  = 1'b1;
    tick();
    chk("en_rise", 64'(ibus_en), 64'd1);
    chk("seq_addr0", ibus_addr, RST_PC);
    tick();
    chk("seq_addr1", ibus_addr, RST_PC + 64'h4);
    chk("seq_valid0", 64'(out_valid), 64'd1);
    chk("seq_pc0", out_pc, RST_PC);
    tick();
    chk("seq_addr2", ibus_addr, RST_PC + 64'h8);
    chk("seq_pc1", out_pc, RST_PC + 64'h4);

    // decode back-pressure fills the buffer
    out_ready = 1'b0;
    restart(RST_PC, 1'b0);
    h0 = hs_cnt;
    repeat (6) tick();
    chk("bp_hs", 64'(hs_cnt - h0), 64'd4);
    chk("bp_en", 64'(ibus_en), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_resume_en", 64'(ibus_en), 64'd1);
    chk("bp_resume_addr", ibus_addr, RST_PC + 64'h10);

    // redirect while a request is outstanding
    out_ready = 1'b1;
    restart(RST_PC, 1'b0);
    tick();
    tick();
    ibus_valid  = 1'b0;
    redirect_en = 1'b1;
    redirect_pc = RST_PC + 64'h100;
    tick();
    redirect_en = 1'b0;
    chk("drain_addr0", ibus_addr, RST_PC + 64'h8);
    chk("drain_en", 64'(ibus_en), 64'd1);
    chk("drain_empty0", 64'(out_valid), 64'd0);
    tick();
    tick();
    chk("drain_addr1", ibus_addr, RST_PC + 64'h8);
    chk("drain_empty1", 64'(out_valid), 64'd0);
    ibus_valid = 1'b1;
    tick();
    chk("drain_next", ibus_addr, RST_PC + 64'h100);
    chk("drain_next_en", 64'(ibus_en), 64'd1);
    chk("drain_empty2", 64'(out_valid), 64'd0);

    // access fault on the second fetch
    out_ready = 1'b0;
    restart(RST_PC, 1'b0);
    tick();
    ibus_acc_err = 1'b1;
    tick();
    ibus_acc_err = 1'b0;
    chk("err_en", 64'(ibus_en), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("err_valid", 64'(out_valid), 64'd1);
    chk("err_pc", out_pc, RST_PC + 64'h4);
    chk("err_body", 64'({out_inst, out_exc, out_exc_code}),
        64'({32'h0, 1'b1, 4'd1}));
    repeat (3) tick();
    chk("err_halt", 64'(ibus_en), 64'd0);

    // misaligned redirect target
    h0 = hs_cnt;
    restart(RST_PC + 64'h102, 1'b0);
    tick();
    chk("mis_valid", 64'(out_valid), 64'd1);
    chk("mis_pc", out_pc, RST_PC + 64'h102);
    chk("mis_body", 64'({out_inst, out_exc, out_exc_code}),
        64'({32'h0, 1'b1, 4'd0}));
    chk("mis_en", 64'(ibus_en), 64'd0);
    chk("mis_nobus", 64'(hs_cnt - h0), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // fence_i with idle, full buffer
    restart(RST_PC, 1'b0);
    repeat (6) tick();
    chk("full_idle", 64'(ibus_en), 64'd0);
    redirect_en = 1'b1;
    redirect_pc = RST_PC + 64'h200;
    fence_i_req = 1'b1;
    tick();
    redirect_en = 1'b0;
    fence_i_req = 1'b0;
    chk("fence_pulse", 64'(ibus_fence_i), 64'd1);
    chk("fence_en", 64'(ibus_en), 64'd0);
    tick();
    chk("fence_done", 64'(ibus_fence_i), 64'd0);
    chk("fence_run_en", 64'(ibus_en), 64'd1);
    chk("fence_run_addr", ibus_addr, RST_PC + 64'h200);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      ibus_valid   = $urandom_range(0, 9) < 7;
      ibus_acc_err = $urandom_range(0, 31) == 0;
      out_ready    = $urandom_range(0, 9) < 6;
      redirect_en  = $urandom_range(0, 24) == 0;
      fence_i_req  = 1'b0;
      if (redirect_en) begin
        off = $urandom_range(0, 63);
        redirect_pc = RST_PC + 64'(off * 4);
        if ($urandom_range(0, 7) == 0)
          redirect_pc[1:0] = 2'($urandom_range(1, 3));
        else
          fence_i_req = $urandom_range(0, 3) == 0;
      end
      tick();
    end
    redirect_en = 1'b0;
    fence_i_req = 1'b0;

    // steady stream must sustain close to one packet per cycle
    out_ready = 1'b1;
    restart(RST_PC + 64'h1000, 1'b0);
    h0 = npop;
    repeat (20) tick();
    chk("liveness", 64'(npop - h0 >= 15), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
